// File: rtl/one_unit_pkg.sv
// Shared definitions for the one-unit iteration sequencer and the blocks
// built around it (state encoding, width helpers, default threshold).
package one_unit_pkg;

  // Ceiling log2, never below 1 so that index ports keep a real width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < value; i++) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Dot-product accumulator width: full products plus growth for N_DIM terms.
  function automatic int acc_width(input int data_w, input int n_dim);
    return 2 * data_w + clog2(n_dim);
  endfunction

  localparam int      DEF_N_DIM    = 4;
  localparam int      DEF_DATA_W   = 16;
  localparam int      DEF_FRAC_W   = 14;
  localparam int      DEF_MAX_ITER = 64;
  // 0.999 expressed with 2*FRAC_W fractional bits.
  localparam longint  DEF_CONV_THR = 64'd268167021;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DECIDE = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ARM    = ST_ARM,
    RUN    = ST_RUN,
    CHECK  = ST_CHECK,
    DECIDE = ST_DECIDE
  } iter_state_t;

endpackage

// File: rtl/one_unit_dot_mac.sv
// Serial signed multiply-accumulate: one full-precision product per enabled
// cycle, sign-extended into a wrapping accumulator.
module one_unit_dot_mac
  import one_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_N_DIM)
) (
  input  logic                     clk_fast,
  input  logic                     rst_fast,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = $signed({{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod});

  // Accumulate one product per enabled cycle; clear wins over enable.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast)  acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc + prod_ext;
  end

endmodule

// File: rtl/one_unit_iter_controller.sv
// Iteration sequencer upstream of the one-unit fast-path controller: runs a
// pass, computes dot(w_new, w_old) serially, then commits and repeats or stops.
module one_unit_iter_controller
  import one_unit_pkg::*;
#(
  parameter int     N_DIM    = DEF_N_DIM,
  parameter int     DATA_W   = DEF_DATA_W,
  parameter int     FRAC_W   = DEF_FRAC_W,
  parameter int     MAX_ITER = DEF_MAX_ITER,
  parameter longint CONV_THR = DEF_CONV_THR
) (
  input  logic                       clk_fast,
  input  logic                       rst_fast,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       fast_busy,
  output logic                       go_fast,
  output logic [clog2(N_DIM)-1:0]    w_addr,
  input  logic signed [DATA_W-1:0]   w_new_data,
  input  logic signed [DATA_W-1:0]   w_old_data,
  output logic                       w_commit,
  output logic [7:0]                 iter_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       converged
);

  localparam int AW    = clog2(N_DIM);
  localparam int CW    = AW + 1;
  localparam int ACC_W = acc_width(DATA_W, N_DIM);

  localparam logic [CW-1:0] CHK_LAST      = CW'(N_DIM);
  localparam logic [CW-1:0] CHK_ADDR_LAST = CW'(N_DIM - 1);
  localparam logic [7:0]    MAX_ITER_C    = 8'(MAX_ITER);
  localparam logic [ACC_W:0] THR          = CONV_THR[ACC_W:0];

  iter_state_t state, state_d;

  logic                  go_fast_d, w_commit_d, busy_d, done_d, converged_d;
  logic [AW-1:0]         w_addr_d;
  logic [7:0]            iter_cnt_d;
  logic [CW-1:0]         chk_cnt, chk_cnt_d, chk_cnt_inc;
  logic                  fast_busy_q;
  logic                  pass_end;
  logic                  mac_clr, mac_en;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W:0]        acc_ext, acc_abs;
  logic                  conv;

  one_unit_dot_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk_fast (clk_fast),
    .rst_fast (rst_fast),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (w_new_data),
    .b        (w_old_data),
    .acc      (acc)
  );

  // Data for w_addr arrives one cycle later, so CHECK cycle 0 accumulates nothing.
  assign mac_clr     = (state != CHECK);
  assign mac_en      = (state == CHECK) && (chk_cnt != '0);
  assign chk_cnt_inc = chk_cnt + 1'b1;
  assign pass_end    = fast_busy_q && !fast_busy;

  // Magnitude on one extra bit so the most-negative accumulator value is exact.
  assign acc_ext = {acc[ACC_W-1], acc};
  assign acc_abs = acc_ext[ACC_W] ? (~acc_ext + 1'b1) : acc_ext;
  assign conv    = (acc_abs >= THR);

  // Next-state and next-output logic; abort overrides every state.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    go_fast_d   = go_fast;
    w_addr_d    = w_addr;
    w_commit_d  = 1'b0;
    iter_cnt_d  = iter_cnt;
    done_d      = 1'b0;
    converged_d = converged;
    chk_cnt_d   = chk_cnt;
    if (abort) begin
      state_d   = IDLE;
      go_fast_d = 1'b0;
      w_addr_d  = '0;
      chk_cnt_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            iter_cnt_d  = 8'd0;
            converged_d = 1'b0;
            go_fast_d   = 1'b1;
            state_d     = ARM;
          end
        end
        ARM: begin
          go_fast_d = 1'b1;
          if (fast_busy) state_d = RUN;
        end
        RUN: begin
          if (pass_end) begin
            go_fast_d  = 1'b0;
            iter_cnt_d = (iter_cnt == 8'hFF) ? iter_cnt : iter_cnt + 8'd1;
            w_addr_d   = '0;
            chk_cnt_d  = '0;
            state_d    = CHECK;
          end
        end
        CHECK: begin
          chk_cnt_d = chk_cnt_inc;
          w_addr_d  = (chk_cnt < CHK_ADDR_LAST) ? chk_cnt_inc[AW-1:0] : '0;
          if (chk_cnt == CHK_LAST) begin
            chk_cnt_d = '0;
            state_d   = DECIDE;
          end
        end
        DECIDE: begin
          if (conv) begin
            converged_d = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (iter_cnt == MAX_ITER_C) begin
            converged_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            w_commit_d = 1'b1;
            go_fast_d  = 1'b1;
            state_d    = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      state       <= IDLE;
      go_fast     <= 1'b0;
      w_addr      <= '0;
      w_commit    <= 1'b0;
      iter_cnt    <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      chk_cnt     <= '0;
      fast_busy_q <= 1'b0;
    end else begin
      state       <= state_d;
      go_fast     <= go_fast_d;
      w_addr      <= w_addr_d;
      w_commit    <= w_commit_d;
      iter_cnt    <= iter_cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      converged   <= converged_d;
      chk_cnt     <= chk_cnt_d;
      fast_busy_q <= fast_busy;
    end
  end

endmodule

// File: tb/tb_one_unit_iter_controller.sv
// Directed bench for one_unit_iter_controller with a fast-path busy model and
// a registered weight-RAM model (1-cycle read latency).
module tb_one_unit_iter_controller;

  localparam int N_DIM = 4;
  localparam int AW    = 2;

  logic                clk_fast = 1'b0;
  logic                rst_fast = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                fast_busy = 1'b0;
  logic                go_fast;
  logic [AW-1:0]       w_addr;
  logic signed [15:0]  w_new_data = '0;
  logic signed [15:0]  w_old_data = '0;
  logic                w_commit;
  logic [7:0]          iter_cnt;
  logic                busy, done, converged;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] mem_new [N_DIM];
  logic signed [15:0] mem_old [N_DIM];
  logic [AW-1:0]      addr_q = '0;
  int                 fb_cnt = 0;

  int commit_cnt = 0;
  int low_run    = 0;
  int had_high   = 0;
  int gap_min    = 1000;
  int gap_max    = 0;
  int gap_seen   = 0;

  one_unit_iter_controller #(
    .MAX_ITER (3)
  ) dut (
    .clk_fast   (clk_fast),
    .rst_fast   (rst_fast),
    .start      (start),
    .abort      (abort),
    .fast_busy  (fast_busy),
    .go_fast    (go_fast),
    .w_addr     (w_addr),
    .w_new_data (w_new_data),
    .w_old_data (w_old_data),
    .w_commit   (w_commit),
    .iter_cnt   (iter_cnt),
    .busy       (busy),
    .done       (done),
    .converged  (converged)
  );

  always #5 clk_fast = ~clk_fast;

  // Fast-path model: busy rises 4 cycles after go_fast, stays high 132 cycles.
  always @(negedge clk_fast) begin
    if (!go_fast) fb_cnt = 0;
    else          fb_cnt = fb_cnt + 1;
    fast_busy = (fb_cnt > 4) && (fb_cnt <= 136);
  end

  // Weight RAM model: data presented one cycle after the address.
  always @(negedge clk_fast) begin
    w_new_data = mem_new[addr_q];
    w_old_data = mem_old[addr_q];
    addr_q     = w_addr;
  end

  // Monitor: commit pulses and go_fast low gaps between passes of one run.
  always @(negedge clk_fast) begin
    if (w_commit) commit_cnt = commit_cnt + 1;
    if (!busy) begin
      had_high = 0;
      low_run  = 0;
    end else if (go_fast) begin
      if (had_high != 0 && low_run > 0) begin
        gap_seen = gap_seen + 1;
        if (low_run < gap_min) gap_min = low_run;
        if (low_run > gap_max) gap_max = low_run;
      end
      had_high = 1;
      low_run  = 0;
    end else if (had_high != 0) begin
      low_run = low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vecs(input int n0, n1, n2, n3, o0, o1, o2, o3);
    mem_new[0] = 16'(n0); mem_new[1] = 16'(n1); mem_new[2] = 16'(n2); mem_new[3] = 16'(n3);
    mem_old[0] = 16'(o0); mem_old[1] = 16'(o1); mem_old[2] = 16'(o2); mem_old[3] = 16'(o3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk_fast);
      seen = done;
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_fast_busy(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_fast);
      seen = fast_busy;
    end
    check({tag, "_fast_busy_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_check_entry(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_fast);
      seen = busy && !go_fast;
    end
    check({tag, "_check_entry"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_commit(input string tag);
    int  base = commit_cnt;
    logic seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_fast);
      seen = (commit_cnt != base);
    end
    check({tag, "_commit_seen"}, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    int c0;
    logic seen;
    set_vecs(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset values
    repeat (3) @(negedge clk_fast);
    check("rst_go_fast",  {63'd0, go_fast},  64'd0);
    check("rst_busy",     {63'd0, busy},     64'd0);
    check("rst_iter_cnt", {56'd0, iter_cnt}, 64'd0);
    check("rst_w_addr",   {62'd0, w_addr},   64'd0);
    check("rst_done",     {63'd0, done},     64'd0);
    rst_fast = 1'b0;
    @(negedge clk_fast);

    // T1: identical 0.5 vectors -> dot 2^28, converged after one pass
    set_vecs(8192, 8192, 8192, 8192, 8192, 8192, 8192, 8192);
    c0 = commit_cnt;
    pulse_start();
    check("t1_busy",    {63'd0, busy},    64'd1);
    check("t1_go_fast", {63'd0, go_fast}, 64'd1);
    wait_done("t1");
    check("t1_converged", {63'd0, converged}, 64'd1);
    check("t1_iter_cnt",  {56'd0, iter_cnt},  64'd1);
    check("t1_commits",   64'(commit_cnt - c0), 64'd0);
    @(negedge clk_fast);
    check("t1_done_pulse", {63'd0, done},      64'd0);
    check("t1_conv_held",  {63'd0, converged}, 64'd1);
    check("t1_idle",       {63'd0, busy},      64'd0);

    // T2: orthogonal vectors -> timeout after MAX_ITER=3, two commits
    set_vecs(16384, 0, 0, 0, 0, 16384, 0, 0);
    c0 = commit_cnt;
    pulse_start();
    check("t2_conv_cleared", {63'd0, converged}, 64'd0);
    wait_done("t2");
    check("t2_converged", {63'd0, converged}, 64'd0);
    check("t2_iter_cnt",  {56'd0, iter_cnt},  64'd3);
    check("t2_commits",   64'(commit_cnt - c0), 64'd2);

    // T3a: w_new = -w_old -> acc = -2^28, still converged
    set_vecs(-8192, -8192, -8192, -8192, 8192, 8192, 8192, 8192);
    pulse_start();
    wait_done("t3a");
    check("t3a_converged", {63'd0, converged}, 64'd1);
    check("t3a_iter_cnt",  {56'd0, iter_cnt},  64'd1);

    // T3b: all -2.0 -> dot 2^32, magnitude must not overflow
    set_vecs(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    pulse_start();
    wait_done("t3b");
    check("t3b_converged", {63'd0, converged}, 64'd1);

    // T4: abort 60 cycles into the second pass's busy window
    set_vecs(16384, 0, 0, 0, 0, 16384, 0, 0);
    pulse_start();
    wait_commit("t4");
    wait_fast_busy("t4");
    repeat (60) @(negedge clk_fast);
    abort = 1'b1;
    @(negedge clk_fast);
    abort = 1'b0;
    check("t4_go_fast",   {63'd0, go_fast},   64'd0);
    check("t4_busy",      {63'd0, busy},      64'd0);
    check("t4_done",      {63'd0, done},      64'd0);
    check("t4_iter_hold", {56'd0, iter_cnt},  64'd1);
    check("t4_conv_hold", {63'd0, converged}, 64'd0);
    @(negedge clk_fast);
    check("t4_still_idle", {63'd0, busy}, 64'd0);
    check("t4_no_done",    {63'd0, done}, 64'd0);
    pulse_start();
    check("t4_restart_iter", {56'd0, iter_cnt}, 64'd0);
    check("t4_restart_busy", {63'd0, busy},     64'd1);

    // T5: start pulses in RUN and CHECK are ignored; the run still times out
    c0 = commit_cnt;
    wait_fast_busy("t5");
    repeat (20) @(negedge clk_fast);
    pulse_start();
    check("t5_run_start_busy", {63'd0, busy},     64'd1);
    check("t5_run_start_go",   {63'd0, go_fast},  64'd1);
    wait_check_entry("t5");
    check("t5_check_iter", {56'd0, iter_cnt}, 64'd1);
    pulse_start();
    check("t5_check_start_go", {63'd0, go_fast}, 64'd0);
    wait_done("t5");
    check("t5_converged", {63'd0, converged}, 64'd0);
    check("t5_iter_cnt",  {56'd0, iter_cnt},  64'd3);
    check("t5_commits",   64'(commit_cnt - c0), 64'd2);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    abort = 1'b0;
    check("t5_sa_busy",    {63'd0, busy},     64'd0);
    check("t5_sa_go_fast", {63'd0, go_fast},  64'd0);
    check("t5_sa_iter",    {56'd0, iter_cnt}, 64'd3);

    // T6: reset asserted in CHECK with w_addr=2 -> reset values at once
    c0 = commit_cnt;
    pulse_start();
    wait_check_entry("t6");
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_fast);
      seen = (w_addr == 2'd2);
    end
    check("t6_addr2_seen", {63'd0, seen}, 64'd1);
    rst_fast = 1'b1;
    #1;
    check("t6_go_fast",  {63'd0, go_fast},   64'd0);
    check("t6_w_addr",   {62'd0, w_addr},    64'd0);
    check("t6_iter_cnt", {56'd0, iter_cnt},  64'd0);
    check("t6_busy",     {63'd0, busy},      64'd0);
    check("t6_done",     {63'd0, done},      64'd0);
    check("t6_conv",     {63'd0, converged}, 64'd0);
    check("t6_w_commit", {63'd0, w_commit},  64'd0);
    repeat (2) @(negedge clk_fast);
    rst_fast = 1'b0;
    repeat (3) @(negedge clk_fast);
    check("t6_no_commit", 64'(commit_cnt - c0), 64'd0);

    // go_fast low gap between passes: CHECK (N_DIM+1) plus DECIDE (1)
    check("gap_seen_any", {63'd0, (gap_seen > 0)}, 64'd1);
    check("gap_min", 64'(gap_min), 64'(N_DIM + 2));
    check("gap_max", 64'(gap_max), 64'(N_DIM + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
